// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU MEM stage
// (port 0) and the loader (port 1), with a port-1 burst lock and registered read responses.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p1_lock,
  output logic              mem_load,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic [1:0]  gnt_d;
  logic [1:0]  we_w;

  assign we_w = {p1_we, p0_we};

  // Grant is combinational; reset suppresses every access.
  always_comb begin
    gnt_d = 2'b00;
    if (!reset) begin
      if (state_q == LOCKED) begin
        gnt_d[1] = p1_req;
      end else if (p0_req && p1_req) begin
        gnt_d = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_d = {p1_req, p0_req};
      end
    end
  end

  assign p0_gnt = gnt_d[0];
  assign p1_gnt = gnt_d[1];

  always_comb begin
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_d[0]) begin
      mem_load  = ~p0_we;
      mem_store = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (gnt_d[1]) begin
      mem_load  = ~p1_we;
      mem_store = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ARB: begin
          if (gnt_d[1]) begin
            last_q <= 1'b1;
          end else if (gnt_d[0]) begin
            last_q <= 1'b0;
          end
          if (gnt_d[1] && p1_lock) begin
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          // Port 1 stays "last" so port 0 wins the first tie after unlock.
          last_q <= 1'b1;
          if (!p1_lock) begin
            state_q <= ARB;
          end
        end
        default: begin
          state_q <= ARB;
          last_q  <= 1'b1;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic              rvalid_q;
      logic [DATA_W-1:0] rdata_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= gnt_d[gi] & ~we_w[gi];
          if (gnt_d[gi] && !we_w[gi]) begin
            rdata_q <= mem_rdata;
          end
        end
      end
    end
  endgenerate

  assign p0_rvalid = g_resp[0].rvalid_q;
  assign p0_rdata  = g_resp[0].rdata_q;
  assign p1_rvalid = g_resp[1].rvalid_q;
  assign p1_rdata  = g_resp[1].rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMemory model and hand-computed
// expected values for grants, memory drive and read responses.
module tb_dmem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              mem_load, mem_store;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Memory model: combinational read while Load=1, write at the rising edge.
  assign mem_rdata = mem_load ? mem[mem_addr] : '0;
  always @(posedge clk) if (mem_store) mem[mem_addr] <= mem_wdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_lock(p1_lock),
    .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic lk);
    p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = lk;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[20] = 32'h1234_5678;
    reset = 1'b1;
    drive0(1'b1, 1'b0, 10'd10, '0);
    drive1(1'b1, 1'b0, 10'd20, '0, 1'b0);

    // Reset suppresses grants and memory strobes even with requests pending.
    tick(); settle();
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_mem_load", mem_load, 0);
    tick();
    reset = 1'b0;
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);

    // Idle
    chk("idle_load", mem_load, 0);
    chk("idle_store", mem_store, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_wdata", mem_wdata, 0);

    // Solo write then solo read on port 0
    drive0(1'b1, 1'b1, 10'd10, 32'hDEAD_BEEF);
    settle();
    chk("wr_p0_gnt", p0_gnt, 1);
    chk("wr_mem_store", mem_store, 1);
    chk("wr_mem_load", mem_load, 0);
    chk("wr_mem_addr", mem_addr, 10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_p0_rvalid", p0_rvalid, 0);
    drive0(1'b1, 1'b0, 10'd10, '0);
    settle();
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_mem_load", mem_load, 1);
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    settle();
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    tick(); settle();
    chk("rd_p0_rvalid_drop", p0_rvalid, 0);
    chk("rd_p0_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

    // Contention after reset: grants go 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive0(1'b1, 1'b0, 10'd10, '0);
    drive1(1'b1, 1'b0, 10'd20, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("cont%0d_p0_gnt", i), p0_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cont%0d_p1_gnt", i), p1_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("cont%0d_addr", i), mem_addr, (i % 2 == 0) ? 10 : 20);
      tick();
      chk($sformatf("cont%0d_p0_rvalid", i), p0_rvalid, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cont%0d_p1_rvalid", i), p1_rvalid, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) chk($sformatf("cont%0d_p1_rdata", i), p1_rdata, 32'h1234_5678);
      else            chk($sformatf("cont%0d_p0_rdata", i), p0_rdata, 32'hDEAD_BEEF);
    end
    drive1(1'b0, 1'b0, '0, '0, 1'b0);

    // Lock burst: p0 granted once so p1 wins the opening tie, then p1 locks
    settle();
    chk("pre_lock_p0_gnt", p0_gnt, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 1'b1, 10'(100 + i), 32'(i + 1), 1'b1);
      settle();
      chk($sformatf("lock%0d_p0_gnt", i), p0_gnt, 0);
      chk($sformatf("lock%0d_p1_gnt", i), p1_gnt, 1);
      chk($sformatf("lock%0d_store", i), mem_store, 1);
      chk($sformatf("lock%0d_addr", i), mem_addr, 100 + i);
      tick();
    end
    // Lock falls while p0 requests: still LOCKED this cycle
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    chk("unlock_edge_p0_gnt", p0_gnt, 0);
    chk("unlock_edge_load", mem_load, 0);
    tick();
    drive1(1'b1, 1'b0, 10'd101, '0, 1'b0);
    settle();
    chk("post_lock_tie_p0", p0_gnt, 1);
    chk("post_lock_tie_p1", p1_gnt, 0);
    tick(); settle();
    chk("post_lock_p1_gnt", p1_gnt, 1);
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    chk("burst_data_p1_rvalid", p1_rvalid, 1);
    chk("burst_data_p1_rdata", p1_rdata, 32'h2);

    // Reset mid-read: pending response is discarded and last returns to 1
    drive0(1'b1, 1'b0, 10'd10, '0);
    settle();
    chk("midrd_p0_gnt", p0_gnt, 1);
    tick();
    reset = 1'b1;
    drive1(1'b1, 1'b0, 10'd20, '0, 1'b0);
    settle();
    chk("midrd_rst_p0_gnt", p0_gnt, 0);
    chk("midrd_rst_p1_gnt", p1_gnt, 0);
    chk("midrd_rst_store", mem_store, 0);
    tick();
    reset = 1'b0;
    settle();
    chk("midrd_p0_rvalid", p0_rvalid, 0);
    chk("midrd_p0_rdata", p0_rdata, 0);
    chk("midrd_tie_p0", p0_gnt, 1);
    chk("midrd_tie_p1", p1_gnt, 0);
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0, 1'b0);

    // Cross-port write then read of the same address
    drive1(1'b1, 1'b1, 10'd5, 32'hCAFE_F00D, 1'b0);
    settle();
    chk("xw_p1_gnt", p1_gnt, 1);
    tick();
    drive1(1'b0, 1'b0, '0, '0, 1'b0);
    drive0(1'b1, 1'b0, 10'd5, '0);
    settle();
    chk("xr_p1_rvalid", p1_rvalid, 0);
    chk("xr_p0_gnt", p0_gnt, 1);
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    settle();
    chk("xr_p0_rvalid", p0_rvalid, 1);
    chk("xr_p0_rdata", p0_rdata, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported `DataMemory` between the CPU MEM stage (port 0) and the program/debug loader (port 1). It issues at most one access per cycle, using round-robin arbitration with an optional port-1 burst lock. It drives the memory's `Load`/`Store`/`Address`/`DataIn` and returns registered read data to the winning requester. It sits between the pipeline's MEM stage, the loader and `DataMemory`.

## Interface
- `ADDR_W`, 10, word address width; matches the `DataMemory` `Address` port.
- `DATA_W`, 32, data width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p0_req`  in  1  port 0 (CPU) access request.
- `p0_we`  in  1  port 0 write (1) or read (0).
- `p0_addr`  in  ADDR_W  port 0 word address.
- `p0_wdata`  in  DATA_W  port 0 write data.
- `p0_gnt`  out  1  port 0 access granted this cycle (combinational).
- `p0_rvalid`  out  1  port 0 read data valid (registered).
- `p0_rdata`  out  DATA_W  port 0 read data.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_rvalid`, `p1_rdata`: same as port 0, for port 1 (loader).
- `p1_lock`  in  1  port 1 requests exclusive ownership for a burst.
- `mem_load`  out  1  to `DataMemory` `Load`.
- `mem_store`  out  1  to `DataMemory` `Store`.
- `mem_addr`  out  ADDR_W  to `DataMemory` `Address`.
- `mem_wdata`  out  DATA_W  to `DataMemory` `DataIn`.
- `mem_rdata`  in  DATA_W  from `DataMemory` `DataOut`; combinational while `Load`=1, 0 otherwise.

## Operation
- Registers:
  - `last` (1 bit): port granted most recently. Reset value 1, so port 0 wins the first tie.
  - `state`: `ARB` or `LOCKED`.
  - Response registers: `rvalid` and `rdata` for each port.
- `ARB` state:
  - Only one requester: grant it.
  - Both request: grant the port ≠ `last`.
  - `last` updates to the granted port on every grant.
- `ARB` → `LOCKED`: when port 1 is granted with `p1_lock`=1.
- `LOCKED` state:
  - Only port 1 is granted; `p0_gnt`=0 regardless of `p0_req`.
  - `LOCKED` → `ARB` at the first rising edge where `p1_lock`=0, whether or not `p1_req` is high.
  - `last` is held at 1 throughout, so port 0 wins the first tie after unlock.
- Memory drive:
  - Granted port: `mem_addr`=addr, `mem_wdata`=wdata, `mem_store`=we, `mem_load`=~we.
  - No grant: `mem_load`=`mem_store`=0, `mem_addr`=0, `mem_wdata`=0.
- Handshake:
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it samples `gnt`=1 at a rising edge.
  - The access completes at that edge.
  - A requester may deassert `req` without ever being granted; nothing is issued for it.
- Reads: at the grant edge, `mem_rdata` is captured into the granted port's `rdata`, and that port's `rvalid` is set for exactly one cycle.
- Writes: no response; `rvalid` stays 0.
- `rdata` holds its last captured value until the next granted read for that port.
- Back-to-back grants to the same port are allowed every cycle; `rvalid` may stay high across consecutive reads.

## Timing
- Grant latency: 0 cycles. `gnt` is combinational from `req`, `state` and `last`.
- Read latency: 1 cycle. A read granted in cycle N gives `rvalid`=1 and valid `rdata` in cycle N+1.
- Write latency: the write is committed at the rising edge that ends the grant cycle.
- Throughput: one access per cycle total.
- Starvation bound: under continuous contention with no lock, each port waits at most 1 cycle.
- Reset:
  - Takes effect at the rising edge where `reset`=1.
  - While `reset`=1, both `gnt` outputs, `mem_load` and `mem_store` are forced to 0, so no access is issued.
  - After the reset edge: `state`=`ARB`, `last`=1, both `rvalid`=0, both `rdata`=0.
- Reset mid-operation:
  - A read granted in the cycle before reset produces no `rvalid` after reset; reset clears it.
  - A `LOCKED` burst is abandoned.
- Simultaneous events:
  - A port-0 request arriving in the same cycle `p1_lock` falls is not granted that cycle; `state` is still `LOCKED` until the edge.
  - When both ports target the same address, the access order follows the grant order.

## Test plan
- Solo write, then solo read:
  - p0 writes 0xDEADBEEF to address 10 → `p0_gnt`=1 the same cycle, `mem_store`=1.
  - p0 then reads address 10 → the next cycle shows `p0_rvalid`=1, `p0_rdata`=0xDEADBEEF.
- Contention after reset:
  - Both ports read continuously (p0 address 10, p1 address 20, where address 20 holds 0x12345678).
  - Required: grants alternate 0, 1, 0, 1 starting with port 0.
  - `p1_rdata`=0x12345678 one cycle after each p1 grant.
- Lock burst:
  - p1 writes 0x1..0x4 to addresses 100..103 with `p1_lock`=1 while p0 requests throughout.
  - Required: `p0_gnt`=0 for all 4 cycles.
  - After `p1_lock` falls, p0 is granted on the next tie.
- Idle: no requests → `mem_load`=`mem_store`=0, `mem_addr`=0, both `rvalid`=0.
- Reset mid-read:
  - p0 read granted at address 10, with `reset`=1 asserted in the following cycle.
  - Required: `p0_rvalid`=0 and `p0_rdata`=0 after the reset edge; the first tie after reset goes to port 0.
- Write then read, same address, different ports:
  - p1 writes 0xCAFEF00D to address 5; p0 reads address 5 in the following cycle.
  - Required: `p0_rdata`=0xCAFEF00D.
